// File: rtl/iter_shifter.sv
// Multi-cycle shift/rotate engine: moves the latched word one bit per clock, with valid/ready on both sides.
// Latency shift_amt+1 cycles from accept; the result is held in DONE until out_ready, and no new request is taken meanwhile.
module iter_shifter #(
    parameter int WIDTH = 4,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic [AMT_W-1:0] shift_amt,
    input  logic             dir,
    input  logic             rotate,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [AMT_W-1:0] AMT_ONE = AMT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_data;
    logic [AMT_W-1:0] r_count;
    logic             r_dir;
    logic             r_rot;
    logic [WIDTH-1:0] w_shl;
    logic [WIDTH-1:0] w_shr;

    // The fill bit is the one falling off the far end when rotating, zero otherwise.
    assign w_shl = {r_data[WIDTH-2:0], r_rot ? r_data[WIDTH-1] : 1'b0};
    assign w_shr = {r_rot ? r_data[0] : 1'b0, r_data[WIDTH-1:1]};

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign data_out  = r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = (shift_amt == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_count == AMT_ONE) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath keeps its value in IDLE and DONE unless a new request is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_count <= '0;
            r_dir   <= 1'b0;
            r_rot   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_data  <= data_in;
                        r_count <= shift_amt;
                        r_dir   <= dir;
                        r_rot   <= rotate;
                    end
                end
                S_SHIFT: begin
                    r_data  <= r_dir ? w_shr : w_shl;
                    r_count <= r_count - AMT_ONE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_shifter.sv
// Bench for iter_shifter: directed cases, backpressure, mid-operation reset and a back-to-back sweep.
// Expected results come from a barrel-shifter reference and are queued at drive time, compared at output.
module tb_iter_shifter;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] data_in;
    logic [1:0] shift_amt;
    logic       dir;
    logic       rotate;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] data_out;
    logic       busy;

    int         n_checks;
    int         n_fail;
    logic [3:0] sb_q[$];

    iter_shifter #(.WIDTH(4), .AMT_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .shift_amt (shift_amt),
        .dir       (dir),
        .rotate    (rotate),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference barrel shifter built on a doubled word.
    function automatic logic [3:0] ref_shift(input logic [3:0] d, input logic [1:0] a,
                                             input logic dr, input logic rt);
        logic [7:0] dbl;
        logic [7:0] tmp;
        logic [3:0] res;
        if (!rt) begin
            res = dr ? (d >> a) : (d << a);
        end else begin
            dbl = {d, d};
            if (dr) begin
                tmp = dbl >> a;
                res = tmp[3:0];
            end else begin
                tmp = dbl << a;
                res = tmp[7:4];
            end
        end
        return res;
    endfunction

    task automatic send(input logic [3:0] d, input logic [1:0] a, input logic dr,
                        input logic rt, input logic [3:0] exp, output bit acc);
        data_in   = d;
        shift_amt = a;
        dir       = dr;
        rotate    = rt;
        in_valid  = 1'b1;
        acc       = in_ready;
        if (acc) sb_q.push_back(exp);
        @(negedge clk);
        in_valid  = 1'b0;
        data_in   = ~d;
        shift_amt = ~a;
        dir       = ~dr;
        rotate    = ~rt;
    endtask

    task automatic wait_result(output logic [3:0] d, output int lat);
        lat = 1;
        while (!out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        d = data_out;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        data_in   = 4'hF;
        shift_amt = 2'd0;
        dir       = 1'b0;
        rotate    = 1'b0;
        out_ready = 1'b0;
        #2;
        n_checks++;
        if ({out_valid, busy, in_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL reset_flags: out_valid/busy/in_ready got %b want 001", {out_valid, busy, in_ready});
        end
        n_checks++;
        if (data_out !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h want 0", data_out);
        end
        @(negedge clk);
        n_checks++;
        if (data_out !== 4'h0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_capture: data_out %h busy %b want 0 0", data_out, busy);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [3:0] d_t[6]   = '{4'hB, 4'hB, 4'hB, 4'hB, 4'hB, 4'hB};
        logic [1:0] a_t[6]   = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd3};
        logic       dr_t[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic       rt_t[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [3:0] exp_t[6] = '{4'hC, 4'h2, 4'hE, 4'hE, 4'hB, 4'hD};
        logic [3:0] got;
        logic [3:0] exp;
        int         lat;
        bit         acc;
        for (int i = 0; i < 6; i++) begin
            send(d_t[i], a_t[i], dr_t[i], rt_t[i], exp_t[i], acc);
            n_checks++;
            if (acc !== 1'b1) begin
                n_fail++;
                $display("FAIL basic_accept[%0d]: in_ready got %b want 1", i, acc);
            end
            wait_result(got, lat);
            exp = (sb_q.size() > 0) ? sb_q.pop_front() : 4'hx;
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL basic_data[%0d]: got %b want %b", i, got, exp);
            end
            n_checks++;
            if (lat !== int'(a_t[i]) + 1) begin
                n_fail++;
                $display("FAIL basic_latency[%0d]: got %0d want %0d", i, lat, int'(a_t[i]) + 1);
            end
            consume();
            n_checks++;
            if ({out_valid, in_ready, busy} !== 3'b010) begin
                n_fail++;
                $display("FAIL basic_idle[%0d]: out_valid/in_ready/busy got %b want 010", i, {out_valid, in_ready, busy});
            end
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] got;
        logic [3:0] exp;
        int         lat;
        bit         acc;
        send(4'hB, 2'd1, 1'b1, 1'b0, 4'h5, acc);
        wait_result(got, lat);
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 4'hx;
        for (int i = 0; i < 5; i++) begin
            in_valid  = 1'b1;
            data_in   = 4'(i);
            shift_amt = 2'd0;
            @(negedge clk);
            n_checks++;
            if ({out_valid, in_ready} !== 2'b10 || data_out !== exp) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: out_valid/in_ready %b data %b want 10 %b", i, {out_valid, in_ready}, data_out, exp);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01 || data_out !== exp) begin
            n_fail++;
            $display("FAIL bp_release: out_valid/in_ready %b data %b want 01 %b", {out_valid, in_ready}, data_out, exp);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] got;
        logic [3:0] exp;
        int         lat;
        bit         acc;
        send(4'hB, 2'd3, 1'b0, 1'b0, 4'h8, acc);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_busy: got %b want 1", busy);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, busy} !== 2'b00 || data_out !== 4'h0) begin
            n_fail++;
            $display("FAIL rstmid_abort: out_valid/busy %b data %b want 00 0000", {out_valid, busy}, data_out);
        end
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(4'h6, 2'd1, 1'b0, 1'b0, 4'hC, acc);
        wait_result(got, lat);
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 4'hx;
        n_checks++;
        if (got !== exp || lat !== 2) begin
            n_fail++;
            $display("FAIL rstmid_after: data %b lat %0d want %b 2", got, lat, exp);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        localparam int N = 356;
        logic [3:0] exp;
        int         k;
        int         cyc;
        int         last_acc;
        int         last_amt;
        bit         acc_pending;
        k           = 0;
        cyc         = 0;
        last_acc    = -1;
        last_amt    = 0;
        acc_pending = 1'b0;
        {data_in, shift_amt, dir, rotate} = 8'd0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        while ((k < N || sb_q.size() > 0) && cyc < 5000) begin
            if (out_valid) begin
                exp = (sb_q.size() > 0) ? sb_q.pop_front() : 4'hx;
                n_checks++;
                if (data_out !== exp) begin
                    n_fail++;
                    $display("FAIL b2b_data: cycle %0d got %b want %b", cyc, data_out, exp);
                end
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(ref_shift(data_in, shift_amt, dir, rotate));
                if (last_acc >= 0) begin
                    n_checks++;
                    if (cyc - last_acc !== last_amt + 2) begin
                        n_fail++;
                        $display("FAIL b2b_interval: got %0d want %0d", cyc - last_acc, last_amt + 2);
                    end
                end
                last_acc    = cyc;
                last_amt    = int'(shift_amt);
                k++;
                acc_pending = 1'b1;
            end
            @(negedge clk);
            cyc++;
            if (acc_pending) begin
                acc_pending = 1'b0;
                if (k < 256) begin
                    {data_in, shift_amt, dir, rotate} = 8'(k);
                end else if (k < N) begin
                    {data_in, shift_amt, dir, rotate} = 8'($urandom_range(0, 255));
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_checks++;
        if (k !== N || sb_q.size() !== 0) begin
            n_fail++;
            $display("FAIL b2b_complete: accepted %0d want %0d, pending %0d", k, N, sb_q.size());
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
